mult_div_unit: RTL and testbench

//   Multi-cycle HI/LO multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
//   It executes mult/multu/div/divu over several cycles and applies mthi/mtlo in a single cycle.

---
 rtl/mult_div_unit.sv | 97 +++++++++
 tb/tb_mult_div_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit with single-cycle mthi/mtlo.
// Optional cancel input Abort is enabled by defining MDU_ABORT_EN.
module mult_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
`ifdef MDU_ABORT_EN
    ,
    input  logic        Abort
`endif
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0] r_pend;
    logic        r_wb;
    logic        w_abort;
    logic        w_mdop;
    logic        w_sdiv;
    logic        w_na;
    logic        w_nb;
    logic        w_divz;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [63:0] w_prod;
    logic [63:0] w_res;
`ifdef MDU_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif
    assign w_mdop = (MDOp < 3'd4);
    // One shared multiplier: the low 64 bits of a product of sign-extended operands give mult
    assign w_prod = {{32{MDOp == 3'd0 && SrcA[31]}}, SrcA} * {{32{MDOp == 3'd0 && SrcB[31]}}, SrcB};
    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow
    assign w_sdiv = (MDOp == 3'd2);
    assign w_na   = w_sdiv && SrcA[31];
    assign w_nb   = w_sdiv && SrcB[31];
    assign w_ua   = w_na ? -SrcA : SrcA;
    assign w_ub   = w_nb ? -SrcB : SrcB;
    assign w_divz = (SrcB == 32'd0);
    assign w_uq   = w_divz ? 32'd0 : w_ua / w_ub;
    assign w_ur   = w_divz ? 32'd0 : w_ua % w_ub;
    assign w_res  = MDOp[1] ? {(w_na ? -w_ur : w_ur), ((w_na ^ w_nb) ? -w_uq : w_uq)} : w_prod;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_wb    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            Done <= 1'b0;
            if (r_state == IDLE) begin
                if (Start && !w_abort && w_mdop) begin
                    r_pend  <= w_res;
                    r_wb    <= !(MDOp[1] && w_divz);
                    r_cnt   <= MDOp[1] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                    r_state <= RUN;
                    Busy    <= 1'b1;
                end else if (Start && !w_abort && MDOp == 3'd4) begin
                    HI <= SrcA;
                end else if (Start && !w_abort && MDOp == 3'd5) begin
                    LO <= SrcA;
                end
            end else if (w_abort) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                Busy    <= 1'b0;
            end else if (r_cnt == '0) begin
                if (r_wb) {HI, LO} <= r_pend;
                r_state <= IDLE;
                Busy    <= 1'b0;
                Done    <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n_tests = 0;
    int          n_fail = 0;
    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(clk),
        .Reset(rst),
        .Start(start),
        .MDOp(mdop),
        .SrcA(src_a),
        .SrcB(src_b),
        .Busy(busy),
        .Done(done),
        .HI(hi),
        .LO(lo)
`ifdef MDU_ABORT_EN
        ,
        .Abort(abort)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    // Issues one op, checks Busy for n cycles (optionally re-strobing Start at cycle poke), then the commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int poke);
        @(negedge clk);
        start = 1'b1; mdop = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
            if (i == poke) begin
                start = 1'b1; mdop = 3'd2; src_a = 32'd100; src_b = 32'd7;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b0;
        // mthi then mtlo back to back
        @(negedge clk);
        start = 1'b1; mdop = 3'd4; src_a = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        mdop = 3'd5; src_a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_done", {31'd0, done}, 32'd0);
        // reserved op is a no-op
        start = 1'b1; mdop = 3'd6; src_a = 32'hDEADBEEF; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_hi", hi, 32'h12345678);
        chk("nop_lo", lo, 32'h9ABCDEF0);
        // async reset in cycle 3 of a div
        start = 1'b1; mdop = 3'd2; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_after_busy", {31'd0, busy}, 32'd0);
        chk("arst_after_lo", lo, 32'd0);
        run_op("mult", 3'd0, 32'hFFFFFFFF, 32'h00000002, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, -1);
        run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h00000002, 5, 32'h00000001, 32'hFFFFFFFE, -1);
        run_op("mult_neg", 3'd0, 32'h00010000, 32'hFFFF0000, 5, 32'hFFFFFFFF, 32'h00000000, -1);
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("divu0", 3'd3, 32'h00000007, 32'h00000000, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, -1);
        run_op("div_negb", 3'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, -1);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, -1);
        run_op("divu_big", 3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC, -1);
        run_op("busy_start", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1);
`ifdef MDU_ABORT_EN
        @(negedge clk);
        start = 1'b1; mdop = 3'd2; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd12);
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        start = 1'b1; abort = 1'b1; mdop = 3'd4; src_a = 32'h55AA55AA;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", {31'd0, busy}, 32'd0);
        chk("abort_start_hi", hi, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
